// File: rtl/fcims_sched.sv
// fcims_sched: two-till round-robin price/stock transaction scheduler with running sales total
module fcims_sched #(
  parameter int N_ITEMS = 4,
  parameter int W = 4,
  parameter int TW = 2 * W,
  parameter int IW = $clog2(N_ITEMS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          op0,
  input  logic [IW-1:0] item0,
  input  logic [W-1:0]  qty0,
  input  logic          req1,
  input  logic          op1,
  input  logic [IW-1:0] item1,
  input  logic [W-1:0]  qty1,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_item,
  input  logic [W-1:0]  cfg_price,
  input  logic [W-1:0]  cfg_stock,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [TW-1:0] fprice,
  output logic [W-1:0]  new_ct,
  output logic [TW-1:0] total,
  output logic          sat,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic pref_q, pref_d, gnt_q, gnt_d, op_q, op_d, rerr_q, rerr_d;
  logic sat_q, sat_d, ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
  logic [IW-1:0] item_q, item_d;
  logic [W-1:0] qty_q, qty_d, ws_q, ws_d, rct_q, rct_d, new_ct_q, new_ct_d;
  logic [TW-1:0] prod_q, prod_d, rfp_q, rfp_d, total_q, total_d, fprice_q, fprice_d;
  logic [W-1:0] price_q [N_ITEMS];
  logic [W-1:0] price_d [N_ITEMS];
  logic [W-1:0] stock_q [N_ITEMS];
  logic [W-1:0] stock_d [N_ITEMS];
  logic [W:0] rsum;
  logic [TW:0] tsum;
  logic rej, sale_ok;
  logic [W-1:0] nstock;
  assign rsum = {1'b0, ws_q} + {1'b0, qty_q};
  assign tsum = {1'b0, total_q} + {1'b0, prod_q};
  assign rej = op_q ? (qty_q > ws_q) : rsum[W];
  assign sale_ok = op_q & ~rej;
  assign nstock = rej ? ws_q : (op_q ? ws_q - qty_q : rsum[W-1:0]);
  always_comb begin
    state_d = state_q;
    pref_d = pref_q;
    gnt_d = gnt_q;
    op_d = op_q;
    item_d = item_q;
    qty_d = qty_q;
    ws_d = ws_q;
    prod_d = prod_q;
    rerr_d = rerr_q;
    rfp_d = rfp_q;
    rct_d = rct_q;
    price_d = price_q;
    stock_d = stock_q;
    total_d = total_q;
    sat_d = sat_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    err_d = err_q;
    fprice_d = fprice_q;
    new_ct_d = new_ct_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          price_d[cfg_item] = cfg_price;
          stock_d[cfg_item] = cfg_stock;
        end else if (req0 | req1) begin
          gnt_d = (req0 & req1) ? pref_q : req1;
          op_d = gnt_d ? op1 : op0;
          item_d = gnt_d ? item1 : item0;
          qty_d = gnt_d ? qty1 : qty0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ws_d = stock_q[item_q];
        prod_d = TW'(price_q[item_q]) * TW'(qty_q);
        state_d = EXEC;
      end
      EXEC: begin
        rerr_d = rej;
        rfp_d = sale_ok ? prod_q : '0;
        rct_d = nstock;
        stock_d[item_q] = nstock;
        // total saturates at all-ones; sat stays set until reset
        total_d = sale_ok ? (tsum[TW] ? '1 : tsum[TW-1:0]) : total_q;
        sat_d = sat_q | (sale_ok & tsum[TW]);
        state_d = DONE;
      end
      default: begin
        ack0_d = ~gnt_q;
        ack1_d = gnt_q;
        err_d = rerr_q;
        fprice_d = rfp_q;
        new_ct_d = rct_q;
        pref_d = ~gnt_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pref_q <= 1'b0;
      gnt_q <= 1'b0;
      op_q <= 1'b0;
      item_q <= '0;
      qty_q <= '0;
      ws_q <= '0;
      prod_q <= '0;
      rerr_q <= 1'b0;
      rfp_q <= '0;
      rct_q <= '0;
      price_q <= '{default: '0};
      stock_q <= '{default: '0};
      total_q <= '0;
      sat_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q <= 1'b0;
      fprice_q <= '0;
      new_ct_q <= '0;
    end else begin
      state_q <= state_d;
      pref_q <= pref_d;
      gnt_q <= gnt_d;
      op_q <= op_d;
      item_q <= item_d;
      qty_q <= qty_d;
      ws_q <= ws_d;
      prod_q <= prod_d;
      rerr_q <= rerr_d;
      rfp_q <= rfp_d;
      rct_q <= rct_d;
      price_q <= price_d;
      stock_q <= stock_d;
      total_q <= total_d;
      sat_q <= sat_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      err_q <= err_d;
      fprice_q <= fprice_d;
      new_ct_q <= new_ct_d;
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign err = err_q;
  assign fprice = fprice_q;
  assign new_ct = new_ct_q;
  assign total = total_q;
  assign sat = sat_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_fcims_sched.sv
// tb_fcims_sched: directed self-checking bench for fcims_sched
module tb_fcims_sched;
  logic clk = 1'b0, reset = 1'b0;
  logic req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0, cfg_we = 1'b0;
  logic [1:0] item0 = '0, item1 = '0, cfg_item = '0;
  logic [3:0] qty0 = '0, qty1 = '0, cfg_price = '0, cfg_stock = '0;
  logic ack0, ack1, err, sat, busy;
  logic [7:0] fprice, total;
  logic [3:0] new_ct;
  int checks = 0, errors = 0;

  fcims_sched dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .item0(item0), .qty0(qty0),
    .req1(req1), .op1(op1), .item1(item1), .qty1(qty1),
    .cfg_we(cfg_we), .cfg_item(cfg_item), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .ack0(ack0), .ack1(ack1), .err(err), .fprice(fprice), .new_ct(new_ct),
    .total(total), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] it, input logic [3:0] p, input logic [3:0] s);
    @(negedge clk);
    cfg_we = 1'b1; cfg_item = it; cfg_price = p; cfg_stock = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_ack(input logic t, output int n);
    n = 0;
    forever begin
      @(posedge clk); #1;
      n++;
      if ((t ? ack1 : ack0) === 1'b1 || n > 12) break;
    end
  endtask

  task automatic txn(input string tag, input logic t, input logic op, input logic [1:0] it,
                     input logic [3:0] q, input logic e_err, input int e_fp, input int e_ct,
                     input int e_tot);
    int n;
    @(negedge clk);
    if (t) begin req1 = 1'b1; op1 = op; item1 = it; qty1 = q; end
    else begin req0 = 1'b1; op0 = op; item0 = it; qty0 = q; end
    wait_ack(t, n);
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, ".lat"}, n, 4);
    chk({tag, ".ack_other"}, t ? ack0 : ack1, 0);
    chk({tag, ".err"}, err, e_err);
    chk({tag, ".fprice"}, fprice, e_fp);
    chk({tag, ".new_ct"}, new_ct, e_ct);
    chk({tag, ".total"}, total, e_tot);
    @(negedge clk);
  endtask

  initial begin
    int n, cyc, nack;
    logic [3:0] order;
    int at [4];
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst.ack0", ack0, 0);
    chk("rst.ack1", ack1, 0);
    chk("rst.busy", busy, 0);
    chk("rst.total", total, 0);
    chk("rst.sat", sat, 0);
    chk("rst.err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    // sale, reject, qty=0, restock boundaries
    cfg(2'd1, 4'd4, 4'd3);
    txn("t1.sale", 1'b0, 1'b1, 2'd1, 4'd2, 1'b0, 8, 1, 8);
    txn("t2.reject", 1'b0, 1'b1, 2'd1, 4'd2, 1'b1, 0, 1, 8);
    txn("t2.zero", 1'b0, 1'b1, 2'd1, 4'd0, 1'b0, 0, 1, 8);
    txn("t4.restock", 1'b1, 1'b0, 2'd1, 4'd14, 1'b0, 0, 15, 8);
    txn("t4.overflow", 1'b1, 1'b0, 2'd1, 4'd1, 1'b1, 0, 15, 8);

    // saturation of total
    do_reset();
    cfg(2'd2, 4'd15, 4'd15);
    txn("t5.sale1", 1'b0, 1'b1, 2'd2, 4'd15, 1'b0, 225, 0, 225);
    chk("t5.sat0", sat, 0);
    txn("t5.restock", 1'b1, 1'b0, 2'd2, 4'd15, 1'b0, 0, 15, 225);
    txn("t5.sale2", 1'b0, 1'b1, 2'd2, 4'd15, 1'b0, 225, 0, 255);
    chk("t5.sat1", sat, 1);
    txn("t5.restock2", 1'b0, 1'b0, 2'd2, 4'd1, 1'b0, 0, 1, 255);
    txn("t5.sale3", 1'b1, 1'b1, 2'd2, 4'd1, 1'b0, 15, 0, 255);
    chk("t5.sat_sticky", sat, 1);

    // round robin with both tills held high
    do_reset();
    cfg(2'd0, 4'd1, 4'd15);
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b1; item0 = 2'd0; qty0 = 4'd1;
    req1 = 1'b1; op1 = 1'b1; item1 = 2'd0; qty1 = 4'd1;
    nack = 0; cyc = 0; order = '0;
    while (nack < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        order[nack] = ack1;
        at[nack] = cyc;
        chk("t3.ct", new_ct, 14 - nack);
        chk("t3.total", total, nack + 1);
        nack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t3.nack", nack, 4);
    chk("t3.order", order, 4'b1010);
    chk("t3.first", at[0], 4);
    for (int i = 1; i < 4; i++) chk("t3.gap", at[i] - at[i-1], 4);
    @(negedge clk);

    // reset mid-transaction, cfg ignored while busy
    do_reset();
    cfg(2'd3, 4'd2, 4'd5);
    @(negedge clk);
    req1 = 1'b1; op1 = 1'b1; item1 = 2'd3; qty1 = 4'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6.busy_exec", busy, 1);
    @(negedge clk);
    reset = 1'b1; req1 = 1'b0;
    @(posedge clk); #1;
    chk("t6.busy", busy, 0);
    chk("t6.ack1", ack1, 0);
    chk("t6.total", total, 0);
    @(negedge clk);
    reset = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack1 === 1'b1) nack++;
    end
    chk("t6.no_ack", nack, 0);
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b1; item0 = 2'd0; qty0 = 4'd0;
    @(posedge clk); #1;
    chk("t6.busy_cfg", busy, 1);
    cfg_we = 1'b1; cfg_item = 2'd3; cfg_price = 4'd2; cfg_stock = 4'd5;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    wait_ack(1'b0, n);
    req0 = 1'b0;
    chk("t6.ack0", ack0, 1);
    @(negedge clk);
    txn("t6.empty", 1'b0, 1'b1, 2'd3, 4'd1, 1'b1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
